// File: rtl/glb_bank_sram_arbiter_if.sv
// Requester, read-return and SRAM-side signals of the bank SRAM arbiter.
// The slave modport is the arbiter; the master modport is the requesters plus the SRAM macro.
interface glb_bank_sram_arbiter_if #(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 64
);
  logic [NUM_REQ-1:0]                  req_valid;
  logic [NUM_REQ-1:0]                  req_ready;
  logic [NUM_REQ-1:0]                  req_wr_en;
  logic [NUM_REQ*ADDR_WIDTH-1:0]       req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0]       req_wr_data;
  logic [NUM_REQ*(DATA_WIDTH/8)-1:0]   req_wr_strb;
  logic [NUM_REQ-1:0]                  rd_data_valid;
  logic [DATA_WIDTH-1:0]               rd_data;
  logic                                sram_ceb;
  logic                                sram_web;
  logic [ADDR_WIDTH-1:0]               sram_a;
  logic [DATA_WIDTH-1:0]               sram_d;
  logic [DATA_WIDTH-1:0]               sram_bweb;
  logic [DATA_WIDTH-1:0]               sram_q;
  logic [NUM_REQ*16-1:0]               grant_cnt;

  modport slave (
    input  req_valid, req_wr_en, req_addr, req_wr_data, req_wr_strb, sram_q,
    output req_ready, rd_data_valid, rd_data,
    output sram_ceb, sram_web, sram_a, sram_d, sram_bweb, grant_cnt
  );

  modport master (
    output req_valid, req_wr_en, req_addr, req_wr_data, req_wr_strb, sram_q,
    input  req_ready, rd_data_valid, rd_data,
    input  sram_ceb, sram_web, sram_a, sram_d, sram_bweb, grant_cnt
  );
endinterface

// File: rtl/glb_bank_sram_arbiter.sv
// Round-robin arbiter sharing one bank SRAM between NUM_REQ requesters, with
// read-return routing through a fixed-latency id pipeline and per-requester grant counters.
module glb_bank_sram_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 64,
  parameter int RD_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  glb_bank_sram_arbiter_if.slave bus
);
  localparam int IDW    = $clog2(NUM_REQ);
  localparam int STRB_W = DATA_WIDTH / 8;

  logic [IDW-1:0]        ptr_q, ptr_d;
  logic                  any_grant;
  logic [IDW-1:0]        win_id;
  logic [NUM_REQ-1:0]    grant;
  logic                  win_wr;
  logic [STRB_W-1:0]     win_strb;

  logic [RD_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
  logic [IDW-1:0]        pipe_id_q [RD_LATENCY];
  logic [IDW-1:0]        pipe_id_d [RD_LATENCY];
  logic [15:0]           cnt_q [NUM_REQ];
  logic [15:0]           cnt_d [NUM_REQ];

  // First valid requester at or above ptr, wrapping; reset suppresses any grant.
  always_comb begin
    logic [IDW:0] cand;
    cand      = '0;
    any_grant = 1'b0;
    win_id    = '0;
    for (int o = 0; o < NUM_REQ; o++) begin
      cand = {1'b0, ptr_q} + (IDW+1)'(o);
      if (cand >= (IDW+1)'(NUM_REQ)) cand = cand - (IDW+1)'(NUM_REQ);
      if (!any_grant && bus.req_valid[cand[IDW-1:0]]) begin
        any_grant = 1'b1;
        win_id    = cand[IDW-1:0];
      end
    end
    if (reset) any_grant = 1'b0;
  end

  always_comb begin
    grant = '0;
    if (any_grant) grant[win_id] = 1'b1;
  end

  assign bus.req_ready = grant;
  assign win_wr        = bus.req_wr_en[win_id];
  assign win_strb      = bus.req_wr_strb[win_id*STRB_W +: STRB_W];

  always_comb begin
    ptr_d = ptr_q;
    if (any_grant) ptr_d = (win_id == IDW'(NUM_REQ-1)) ? '0 : win_id + IDW'(1);
  end

  always_comb begin
    bus.sram_ceb  = 1'b1;
    bus.sram_web  = 1'b1;
    bus.sram_a    = '0;
    bus.sram_d    = '0;
    bus.sram_bweb = '1;
    if (any_grant) begin
      bus.sram_ceb = 1'b0;
      bus.sram_web = ~win_wr;
      bus.sram_a   = bus.req_addr[win_id*ADDR_WIDTH +: ADDR_WIDTH];
      bus.sram_d   = bus.req_wr_data[win_id*DATA_WIDTH +: DATA_WIDTH];
      if (win_wr) begin
        for (int b = 0; b < STRB_W; b++) bus.sram_bweb[b*8 +: 8] = {8{~win_strb[b]}};
      end
    end
  end

  always_comb begin
    pipe_vld_d    = '0;
    pipe_vld_d[0] = any_grant && !win_wr;
    pipe_id_d[0]  = win_id;
    for (int i = 1; i < RD_LATENCY; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_id_d[i]  = pipe_id_q[i-1];
    end
  end

  always_comb begin
    bus.rd_data_valid = '0;
    if (!reset && pipe_vld_q[RD_LATENCY-1]) bus.rd_data_valid[pipe_id_q[RD_LATENCY-1]] = 1'b1;
  end

  assign bus.rd_data = bus.sram_q;

  always_comb begin
    bus.grant_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (grant[i] && cnt_q[i] != 16'hFFFF) cnt_d[i] = cnt_q[i] + 16'd1;
      bus.grant_cnt[i*16 +: 16] = cnt_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q      <= '0;
      pipe_vld_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) pipe_id_q[i] <= '0;
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      ptr_q      <= ptr_d;
      pipe_vld_q <= pipe_vld_d;
      for (int i = 0; i < RD_LATENCY; i++) pipe_id_q[i] <= pipe_id_d[i];
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= cnt_d[i];
    end
  end
endmodule

// File: tb/tb_glb_bank_sram_arbiter.sv
// Directed bench for glb_bank_sram_arbiter with a two-stage bank SRAM model.
module tb_glb_bank_sram_arbiter;
  localparam int NR = 3;
  localparam int AW = 14;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  glb_bank_sram_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

  glb_bank_sram_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(2)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Bank memory: input register stage, then the macro cycle.
  logic [DW-1:0] mem [1<<AW];
  logic          s_ceb = 1'b1, s_web = 1'b1;
  logic [AW-1:0] s_a;
  logic [DW-1:0] s_d, s_bweb;
  initial for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
  always @(posedge clk) begin
    s_ceb  <= bus.sram_ceb;
    s_web  <= bus.sram_web;
    s_a    <= bus.sram_a;
    s_d    <= bus.sram_d;
    s_bweb <= bus.sram_bweb;
    if (!s_ceb) begin
      if (!s_web) mem[s_a] <= (mem[s_a] & s_bweb) | (s_d & ~s_bweb);
      else        bus.sram_q <= mem[s_a];
    end
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic clr;
    bus.req_valid   = '0;
    bus.req_wr_en   = '0;
    bus.req_addr    = '0;
    bus.req_wr_data = '0;
    bus.req_wr_strb = '0;
  endtask

  task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [7:0] s);
    bus.req_valid[i]            = 1'b1;
    bus.req_wr_en[i]            = wr;
    bus.req_addr[i*AW +: AW]    = a;
    bus.req_wr_data[i*DW +: DW] = d;
    bus.req_wr_strb[i*8 +: 8]   = s;
  endtask

  task automatic do_reset;
    clr();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    clr();
    reset = 1'b1;
    tick();
    set_req(0, 1'b1, 14'h3, 64'hAA, 8'hFF);
    set_req(1, 1'b0, 14'h4, 64'h0, 8'h0);
    #1;
    n_chk++; if (bus.req_ready !== 3'b000) begin n_fail++; $display("FAIL reset_ready: got %b want 000", bus.req_ready); end
    n_chk++; if (bus.sram_ceb !== 1'b1 || bus.sram_web !== 1'b1) begin n_fail++; $display("FAIL reset_ceb_web: got %b%b want 11", bus.sram_ceb, bus.sram_web); end
    n_chk++; if (bus.sram_a !== '0 || bus.sram_d !== '0 || bus.sram_bweb !== '1) begin n_fail++; $display("FAIL reset_idle_bus: a=%h d=%h bweb=%h", bus.sram_a, bus.sram_d, bus.sram_bweb); end
    tick();
    clr();
    reset = 1'b0;
    #1;
    n_chk++; if (bus.grant_cnt !== '0) begin n_fail++; $display("FAIL reset_cnt: got %h want 0", bus.grant_cnt); end
    n_chk++; if (bus.rd_data_valid !== 3'b000) begin n_fail++; $display("FAIL reset_rdv: got %b want 000", bus.rd_data_valid); end
  endtask

  task automatic test_write_read;
    do_reset();
    set_req(0, 1'b1, 14'h005, 64'h1122334455667788, 8'hFF);
    #1;
    n_chk++; if (bus.req_ready !== 3'b001) begin n_fail++; $display("FAIL wr_ready: got %b want 001", bus.req_ready); end
    n_chk++; if (bus.sram_ceb !== 1'b0 || bus.sram_web !== 1'b0) begin n_fail++; $display("FAIL wr_ceb_web: got %b%b want 00", bus.sram_ceb, bus.sram_web); end
    n_chk++; if (bus.sram_a !== 14'h005 || bus.sram_d !== 64'h1122334455667788 || bus.sram_bweb !== 64'h0) begin n_fail++; $display("FAIL wr_bus: a=%h d=%h bweb=%h", bus.sram_a, bus.sram_d, bus.sram_bweb); end
    tick();
    clr();
    set_req(0, 1'b0, 14'h005, 64'h0, 8'h00);
    #1;
    n_chk++; if (bus.sram_web !== 1'b1 || bus.sram_ceb !== 1'b0 || bus.sram_bweb !== '1) begin n_fail++; $display("FAIL rd_drive: ceb=%b web=%b bweb=%h", bus.sram_ceb, bus.sram_web, bus.sram_bweb); end
    tick();
    clr();
    #1;
    n_chk++; if (bus.rd_data_valid !== 3'b000) begin n_fail++; $display("FAIL rd_early: got %b want 000", bus.rd_data_valid); end
    tick();
    #1;
    n_chk++; if (bus.rd_data_valid !== 3'b001) begin n_fail++; $display("FAIL rd_return_valid: got %b want 001", bus.rd_data_valid); end
    n_chk++; if (bus.rd_data !== 64'h1122334455667788) begin n_fail++; $display("FAIL rd_return_data: got %h want 1122334455667788", bus.rd_data); end
    tick();
    #1;
    n_chk++; if (bus.rd_data_valid !== 3'b000) begin n_fail++; $display("FAIL rd_pulse_width: got %b want 000", bus.rd_data_valid); end
  endtask

  task automatic test_round_robin;
    do_reset();
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, AW'(16 + i), 64'h0, 8'h0);
    for (int c = 0; c < 6; c++) begin
      logic [NR-1:0] exp_rdy;
      exp_rdy = NR'(1) << (c % 3);
      #1;
      n_chk++; if (bus.req_ready !== exp_rdy) begin n_fail++; $display("FAIL rr_order[%0d]: got %b want %b", c, bus.req_ready, exp_rdy); end
      tick();
    end
    clr();
    #1;
    n_chk++; if (bus.grant_cnt !== {16'd2, 16'd2, 16'd2}) begin n_fail++; $display("FAIL rr_cnt: got %h want 000200020002", bus.grant_cnt); end
  endtask

  task automatic test_ptr_wrap;
    do_reset();
    set_req(1, 1'b0, 14'h7, 64'h0, 8'h0);
    #1;
    n_chk++; if (bus.req_ready !== 3'b010) begin n_fail++; $display("FAIL ptr_lone: got %b want 010", bus.req_ready); end
    tick();
    set_req(2, 1'b0, 14'h8, 64'h0, 8'h0);
    #1;
    n_chk++; if (bus.req_ready !== 3'b100) begin n_fail++; $display("FAIL ptr_first: got %b want 100", bus.req_ready); end
    tick();
    bus.req_valid[2] = 1'b0;
    #1;
    n_chk++; if (bus.req_ready !== 3'b010) begin n_fail++; $display("FAIL ptr_second: got %b want 010", bus.req_ready); end
    tick();
    clr();
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, 14'h9, 64'h0, 8'h0);
    #1;
    n_chk++; if (bus.req_ready !== 3'b100) begin n_fail++; $display("FAIL ptr_end: got %b want 100", bus.req_ready); end
    tick();
    clr();
    #1;
    n_chk++; if (bus.grant_cnt !== {16'd2, 16'd2, 16'd0}) begin n_fail++; $display("FAIL ptr_cnt: got %h want 000200020000", bus.grant_cnt); end
  endtask

  task automatic test_partial_write;
    do_reset();
    set_req(1, 1'b1, 14'h020, 64'h0, 8'hFF);
    tick();
    clr();
    set_req(1, 1'b1, 14'h020, 64'hFFFFFFFFFFFFFFFF, 8'h0F);
    #1;
    n_chk++; if (bus.sram_bweb !== 64'hFFFFFFFF00000000) begin n_fail++; $display("FAIL pw_bweb: got %h want ffffffff00000000", bus.sram_bweb); end
    tick();
    clr();
    set_req(1, 1'b1, 14'h020, 64'hDEADBEEFDEADBEEF, 8'h00);
    #1;
    n_chk++; if (bus.sram_ceb !== 1'b0 || bus.sram_web !== 1'b0 || bus.sram_bweb !== '1) begin n_fail++; $display("FAIL zs_drive: ceb=%b web=%b bweb=%h", bus.sram_ceb, bus.sram_web, bus.sram_bweb); end
    tick();
    clr();
    set_req(1, 1'b0, 14'h020, 64'h0, 8'h0);
    tick();
    clr();
    tick();
    #1;
    n_chk++; if (bus.rd_data_valid !== 3'b010) begin n_fail++; $display("FAIL pw_rdv: got %b want 010", bus.rd_data_valid); end
    n_chk++; if (bus.rd_data !== 64'h00000000FFFFFFFF) begin n_fail++; $display("FAIL pw_data: got %h want 00000000ffffffff", bus.rd_data); end
    n_chk++; if (bus.grant_cnt !== {16'd0, 16'd4, 16'd0}) begin n_fail++; $display("FAIL pw_cnt: got %h want 000000040000", bus.grant_cnt); end
  endtask

  task automatic test_back_to_back;
    do_reset();
    set_req(0, 1'b1, 14'h100, 64'hA5A5000011112222, 8'hFF);
    tick();
    clr();
    set_req(2, 1'b1, 14'h200, 64'h5A5AFFFF33334444, 8'hFF);
    tick();
    clr();
    set_req(0, 1'b0, 14'h100, 64'h0, 8'h0);
    #1;
    n_chk++; if (bus.req_ready !== 3'b001) begin n_fail++; $display("FAIL b2b_g0: got %b want 001", bus.req_ready); end
    tick();
    clr();
    set_req(2, 1'b0, 14'h200, 64'h0, 8'h0);
    #1;
    n_chk++; if (bus.req_ready !== 3'b100) begin n_fail++; $display("FAIL b2b_g2: got %b want 100", bus.req_ready); end
    tick();
    clr();
    #1;
    n_chk++; if (bus.rd_data_valid !== 3'b001 || bus.rd_data !== 64'hA5A5000011112222) begin n_fail++; $display("FAIL b2b_ret0: rdv=%b data=%h want 001 a5a5000011112222", bus.rd_data_valid, bus.rd_data); end
    tick();
    #1;
    n_chk++; if (bus.rd_data_valid !== 3'b100 || bus.rd_data !== 64'h5A5AFFFF33334444) begin n_fail++; $display("FAIL b2b_ret2: rdv=%b data=%h want 100 5a5affff33334444", bus.rd_data_valid, bus.rd_data); end
    tick();
    #1;
    n_chk++; if (bus.rd_data_valid !== 3'b000) begin n_fail++; $display("FAIL b2b_tail: got %b want 000", bus.rd_data_valid); end
  endtask

  task automatic test_reset_inflight;
    do_reset();
    set_req(0, 1'b0, 14'h100, 64'h0, 8'h0);
    #1;
    n_chk++; if (bus.req_ready !== 3'b001) begin n_fail++; $display("FAIL rst_if_grant: got %b want 001", bus.req_ready); end
    tick();
    clr();
    set_req(1, 1'b0, 14'h55, 64'h0, 8'h0);
    reset = 1'b1;
    #1;
    n_chk++; if (bus.req_ready !== 3'b000 || bus.sram_ceb !== 1'b1) begin n_fail++; $display("FAIL rst_if_block: ready=%b ceb=%b want 000 1", bus.req_ready, bus.sram_ceb); end
    tick();
    clr();
    reset = 1'b0;
    #1;
    n_chk++; if (bus.rd_data_valid !== 3'b000) begin n_fail++; $display("FAIL rst_if_drop: got %b want 000", bus.rd_data_valid); end
    n_chk++; if (bus.grant_cnt !== '0) begin n_fail++; $display("FAIL rst_if_cnt: got %h want 0", bus.grant_cnt); end
    n_chk++; if (bus.sram_ceb !== 1'b1 || bus.sram_web !== 1'b1 || bus.sram_a !== '0 || bus.sram_d !== '0 || bus.sram_bweb !== '1) begin n_fail++; $display("FAIL rst_if_idle: ceb=%b web=%b a=%h d=%h bweb=%h", bus.sram_ceb, bus.sram_web, bus.sram_a, bus.sram_d, bus.sram_bweb); end
    tick();
    #1;
    n_chk++; if (bus.rd_data_valid !== 3'b000) begin n_fail++; $display("FAIL rst_if_late: got %b want 000", bus.rd_data_valid); end
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, 14'h1, 64'h0, 8'h0);
    #1;
    n_chk++; if (bus.req_ready !== 3'b001) begin n_fail++; $display("FAIL rst_if_ptr: got %b want 001", bus.req_ready); end
    tick();
    clr();
  endtask

  initial begin
    clr();
    tick();
    test_reset();
    test_write_read();
    test_round_robin();
    test_ptr_wrap();
    test_partial_write();
    test_back_to_back();
    test_reset_inflight();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/glb_bank_sram_arbiter.md
Name: glb_bank_sram_arbiter

Overview:
- Shares one global-buffer bank SRAM (the 2048x64-macro-based bank memory) between NUM_REQ requesters, e.g. processor port, stream-write port and stream-read port.
- Performs round-robin arbitration with one grant per cycle, and converts each granted request into active-low SRAM controls.
- Tracks in-flight reads through the fixed SRAM read latency, and routes each returning word back to the requester that issued it.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- ADDR_WIDTH, 14, bank word-address width.
- DATA_WIDTH, 64, word width (multiple of 8).
- RD_LATENCY, 2, cycles from the SRAM-side request cycle to sram_q valid (bank memory: 1 input pipeline stage + 1 macro cycle).

Ports:
- Interface (already decided): one clock; reset is synchronous and active-high.
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester grant, asserted in the accepting cycle.
- req_wr_en  in  NUM_REQ  1=write, 0=read.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed word addresses; requester i occupies slice i.
- req_wr_data  in  NUM_REQ*DATA_WIDTH  packed write data.
- req_wr_strb  in  NUM_REQ*DATA_WIDTH/8  packed byte enables, active-high.
- rd_data_valid  out  NUM_REQ  one-hot pulse marking return of a read word.
- rd_data  out  DATA_WIDTH  read data; shared by all requesters.
- sram_ceb  out  1  chip enable, active-low.
- sram_web  out  1  write enable, active-low.
- sram_a  out  ADDR_WIDTH  address.
- sram_d  out  DATA_WIDTH  write data.
- sram_bweb  out  DATA_WIDTH  bit write enable, active-low.
- sram_q  in  DATA_WIDTH  read data from the SRAM.
- grant_cnt  out  NUM_REQ*16  per-requester saturating grant counters.

Behaviour:
- Handshake:
  - A transfer occurs when req_valid[i] && req_ready[i].
  - Requesters hold valid, addr, data, strb and wr_en stable until accepted; deasserting valid before acceptance is illegal.
  - req_ready is combinational from req_valid and the priority pointer.
  - At most one bit of req_ready is set per cycle, and never for a requester whose valid is low.
- Arbitration:
  - Round-robin with priority pointer ptr (clog2(NUM_REQ) bits).
  - The winner is the first valid requester at or above ptr, searching upward with wrap-around.
  - On a grant to requester k: ptr <= (k+1) mod NUM_REQ.
  - With no grant, ptr holds.
  - A lone valid requester is granted every cycle.
- SRAM drive, combinational in the grant cycle:
  - sram_ceb=0.
  - sram_web = ~wr_en.
  - sram_a, sram_d taken from the winner.
  - sram_bweb[b] = ~strb[b/8].
  - For reads, sram_bweb is all ones.
  - Idle cycle: ceb=1, web=1, a=0, d=0, bweb all ones.
  - A write with all-zero strb is still issued and counted; the memory is unchanged.
- Read return:
  - A shift pipeline of depth RD_LATENCY carries {valid, requester id} for each granted read.
  - At the pipeline tail, rd_data_valid[id] pulses for exactly 1 cycle, with rd_data = sram_q.
  - A read granted in cycle T returns in cycle T+RD_LATENCY.
  - Back-to-back reads return back-to-back, in issue order.
  - Writes do not enter the pipeline.
  - Read-after-write to the same address in consecutive grants returns the new data; the SRAM guarantees this, and the arbiter adds no hazard logic.
- Counters:
  - grant_cnt[i] increments on each grant to requester i and saturates at 16'hFFFF.
- Reset (synchronous):
  - ptr=0.
  - Read pipeline cleared, so rd_data_valid=0.
  - grant_cnt=0.
  - req_ready=0 and SRAM idle values are forced while reset is high.
  - Reads in flight when reset asserts are dropped; no rd_data_valid for them after reset.
- Width rules:
  - clog2 for ptr and id fields.
  - Requester slices are indexed i*W +: W.

Test Plan:
- Single requester 0 writes addr 0x005 data 0x1122334455667788 strb 0xFF, then reads 0x005 -> sram_web=0 then 1; rd_data_valid[0] pulses exactly 2 cycles after the read grant; rd_data=0x1122334455667788.
- All 3 valid continuously for 6 cycles from reset -> grant order 0,1,2,0,1,2; grant_cnt = 2,2,2.
- Requesters 1 and 2 valid, ptr=2 -> requester 2 granted first, then 1; ptr ends at 2.
- Partial write strb 0x0F, data all ones, to a word holding 0 -> read returns 0x00000000FFFFFFFF; sram_bweb = 0xFFFFFFFF00000000 in the write cycle.
- Reads from requester 0 to addr A then requester 2 to addr B in consecutive cycles -> rd_data_valid = 001 then 100 on consecutive cycles, each with the correct data.
- Reset asserted 1 cycle after a read grant -> no rd_data_valid pulse; after reset deasserts: ptr=0, grant_cnt=0, SRAM idle values, req_ready=0 during reset.
